// File: rtl/logic_hamr_pkg.sv
// Shared constants and readback FSM encoding for the capture/readback path.
package logic_hamr_pkg;

  localparam int unsigned RB_ADDR_W      = 13;
  localparam int unsigned RB_BUF_DEPTH   = 512;
  localparam int unsigned RB_MAX_SAMPLES = 266;
  localparam int unsigned RB_RD_TIMEOUT  = 255;
  localparam int unsigned SAMPLE_W       = 8;
  localparam int unsigned NUM_CH         = 8;
  localparam int unsigned IDX_W          = 9;
  localparam int unsigned CH_SEL_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } rb_state_e;

endpackage

// File: rtl/readback_bram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// Read-before-write: a same-cycle read of the written address returns old data.
module readback_bram #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned W     = 8,
  parameter int unsigned AW    = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_o <= '0;
    else        rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/capture_readback.sv
// Fetches a captured sample window from SDRAM into a local readback buffer.
// Optional per-channel edge statistics under `EDGE_STATS_EN.
module capture_readback
  import logic_hamr_pkg::*;
#(
  parameter int unsigned ADDR_W     = RB_ADDR_W,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned BUF_DEPTH  = RB_BUF_DEPTH,
  parameter int unsigned RD_TIMEOUT = RB_RD_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                soft_reset,
  input  logic [IDX_W-1:0]    total_samples,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [IDX_W-1:0]    sample_count,
  output logic                sdram_rd_req,
  output logic [ADDR_W-1:0]   sdram_rd_addr,
  input  logic                sdram_rd_ready,
  input  logic [SAMPLE_W-1:0] sdram_rd_data,
  input  logic                sdram_rd_valid,
  input  logic [IDX_W-1:0]    buf_rd_addr,
  output logic [SAMPLE_W-1:0] buf_rd_data,
  input  logic [CH_SEL_W-1:0] stat_ch,
  output logic [IDX_W-1:0]    stat_edges
);

  localparam int unsigned TMR_W = $clog2(RD_TIMEOUT + 1);
  localparam int unsigned N_W   = IDX_W + 1;

  rb_state_e         state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [N_W-1:0]    n_q;
  logic [TMR_W-1:0]  timer_q;
  logic              busy_q, done_q, err_q, req_q;
  logic [IDX_W-1:0]  count_q;
  logic [ADDR_W-1:0] addr_q;

  logic [N_W-1:0] n_c;
  logic [N_W-1:0] idx_inc_c;
  logic           start_c;
  logic           we_c;

  assign n_c       = (N_W'(total_samples) > N_W'(BUF_DEPTH)) ? N_W'(BUF_DEPTH)
                                                             : N_W'(total_samples);
  assign idx_inc_c = N_W'(idx_q) + N_W'(1);
  assign start_c   = start && !soft_reset && (state_q == ST_IDLE || state_q == ST_DONE);
  assign we_c      = (state_q == ST_WAIT) && sdram_rd_valid && !soft_reset;

  // Readback sequencer: one outstanding read at a time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      timer_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      count_q <= '0;
      addr_q  <= '0;
    end else if (soft_reset) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_c) begin
            idx_q   <= '0;
            n_q     <= n_c;
            count_q <= '0;
            err_q   <= 1'b0;
            addr_q  <= ADDR_W'(BASE_ADDR);
            if (n_c == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_ISSUE;
              done_q  <= 1'b0;
              busy_q  <= 1'b1;
              req_q   <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (req_q && sdram_rd_ready) begin
            req_q   <= 1'b0;
            timer_q <= '0;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (sdram_rd_valid) begin
            idx_q   <= IDX_W'(idx_inc_c);
            count_q <= count_q + IDX_W'(1);
            if (idx_inc_c == n_q) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_ISSUE;
              req_q   <= 1'b1;
              addr_q  <= ADDR_W'(BASE_ADDR) + ADDR_W'(idx_inc_c);
            end
          end else if (timer_q == TMR_W'(RD_TIMEOUT)) begin
            state_q <= ST_DONE;
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign sample_count  = count_q;
  assign sdram_rd_req  = req_q;
  assign sdram_rd_addr = addr_q;

  readback_bram #(
    .DEPTH (BUF_DEPTH),
    .W     (SAMPLE_W),
    .AW    (IDX_W)
  ) u_bram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (we_c),
    .waddr_i (idx_q),
    .wdata_i (sdram_rd_data),
    .raddr_i (buf_rd_addr),
    .rdata_o (buf_rd_data)
  );

`ifdef EDGE_STATS_EN
  logic [SAMPLE_W-1:0] prev_q;
  logic [IDX_W-1:0]    cnt_q [NUM_CH];
  logic [IDX_W-1:0]    stat_q;

  // Saturating per-channel transition counters over the stored stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      stat_q <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) cnt_q[i] <= '0;
    end else begin
      stat_q <= cnt_q[stat_ch];
      if (start_c) begin
        for (int i = 0; i < int'(NUM_CH); i++) cnt_q[i] <= '0;
      end else if (we_c) begin
        prev_q <= sdram_rd_data;
        if (idx_q != '0) begin
          for (int i = 0; i < int'(NUM_CH); i++) begin
            if (sdram_rd_data[i] != prev_q[i] && cnt_q[i] != '1)
              cnt_q[i] <= cnt_q[i] + IDX_W'(1);
          end
        end
      end
    end
  end

  assign stat_edges = stat_q;
`else
  logic unused_stat_ch;
  assign unused_stat_ch = ^stat_ch;
  assign stat_edges     = '0;
`endif

endmodule
